// File: rtl/seven_segment_scan_decoder.sv
// Purpose: snoop a 4-digit multiplexed seven-segment scan and rebuild the shown decimal value as binary.
// Latency: the sample completing a frame comes SETTLE_CYCLES+1 cycles after the input change; score_valid follows 5 cycles after that sample.
// Backpressure: none; this is a passive monitor. Optional DP capture is enabled by defining SEG_SCAN_DP_CAPTURE_EN.
module seven_segment_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int SCORE_WIDTH    = 14,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             anode_signals,
  input  logic [7:0]             display_out,
  output logic [SCORE_WIDTH-1:0] score_out,
  output logic                   score_valid,
  output logic                   pattern_err,
  output logic                   anode_err,
  output logic                   timeout,
  output logic [3:0]             dp_out
);

  localparam int ST_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, CONV, DONE} state_t;

  state_t                 state;
  logic [3:0]             an_q, an_qq;
  logic [7:0]             seg_q, seg_qq;
  logic [ST_W-1:0]        settle_cnt;
  logic                   sampled;
  logic [TO_W-1:0]        tcnt;
  logic [3:0]             seen, seen_nxt;
  logic                   bad, bad_nxt;
  logic [3:0]             digit [4];
  logic [3:0]             digit_nxt [4];
  logic [3:0]             frame_digit [4];
  logic [SCORE_WIDTH-1:0] acc, acc_nxt;
  logic [1:0]             conv_idx;
  logic [1:0]             idx;
  logic                   one_low, changed, sample_fire, digit_we;
  logic                   perr_nxt, aerr_nxt, to_expire, to_pulse;
  logic                   frame_take, frame_drop, conv_last;
  logic [4:0]             dec;

  // {is_digit, value} for an active-low a..g pattern (bit 6 = a, bit 0 = g)
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h10;
      7'b1001111: return 5'h11;
      7'b0010010: return 5'h12;
      7'b0000110: return 5'h13;
      7'b1001100: return 5'h14;
      7'b0100100: return 5'h15;
      7'b0100000: return 5'h16;
      7'b0001111: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0000100: return 5'h19;
      default:    return 5'h00;
    endcase
  endfunction

  // Register the bus once and keep the previous copy to spot changes
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= 4'hF;
      an_qq  <= 4'hF;
      seg_q  <= 8'hFF;
      seg_qq <= 8'hFF;
    end else begin
      an_q   <= anode_signals;
      seg_q  <= display_out;
      an_qq  <= an_q;
      seg_qq <= seg_q;
    end
  end

  // Settle counter: restarts on any change, allows one sample per dwell
  always_ff @(posedge clk) begin
    if (reset || changed) begin
      settle_cnt <= '0;
      sampled    <= 1'b0;
    end else begin
      if (settle_cnt != ST_LAST) settle_cnt <= settle_cnt + ST_W'(1);
      if (sample_fire) sampled <= 1'b1;
    end
  end

  // Sample classification, next seen/bad state, timeout and frame hand-off decisions
  always_comb begin
    changed     = {an_q, seg_q} != {an_qq, seg_qq};
    sample_fire = !changed && (settle_cnt == ST_LAST) && !sampled;
    dec         = seg_decode(seg_q[6:0]);
    one_low     = 1'b1;
    idx         = 2'd0;
    case (an_q)
      4'b0111: idx = 2'd3;
      4'b1011: idx = 2'd2;
      4'b1101: idx = 2'd1;
      4'b1110: idx = 2'd0;
      default: one_low = 1'b0;
    endcase
    digit_we = 1'b0;
    perr_nxt = 1'b0;
    aerr_nxt = 1'b0;
    seen_nxt = seen;
    bad_nxt  = bad;
    if (sample_fire && one_low) begin
      if (dec[4]) begin
        digit_we      = 1'b1;
        seen_nxt[idx] = 1'b1;
      end else begin
        perr_nxt      = 1'b1;
        seen_nxt[idx] = 1'b0;
        bad_nxt       = 1'b1;
      end
    end else if (sample_fire && an_q != 4'hF) begin
      aerr_nxt = 1'b1;
    end
    digit_nxt = digit;
    if (digit_we) digit_nxt[idx] = dec[3:0];
    to_expire = (tcnt == TO_LAST);
    to_pulse  = to_expire && (seen_nxt != 4'h0);
    if (to_expire) begin
      seen_nxt = 4'h0;
      bad_nxt  = 1'b0;
    end
    frame_take = (state == COLLECT) && (seen_nxt == 4'hF) && !bad_nxt;
    frame_drop = (state == COLLECT) && (seen_nxt == 4'hF) && bad_nxt;
    conv_last  = (state == CONV) && (conv_idx == 2'd0);
    acc_nxt    = (acc << 3) + (acc << 1) + SCORE_WIDTH'(frame_digit[conv_idx]);
  end

  // Digit collection, frame FSM, decimal-to-binary conversion and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      seen        <= 4'h0;
      bad         <= 1'b0;
      tcnt        <= '0;
      acc         <= '0;
      conv_idx    <= 2'd0;
      score_out   <= '0;
      score_valid <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
      timeout     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit[i]       <= 4'h0;
        frame_digit[i] <= 4'h0;
      end
    end else begin
      pattern_err <= perr_nxt;
      anode_err   <= aerr_nxt;
      timeout     <= to_pulse;
      score_valid <= 1'b0;
      digit       <= digit_nxt;
      seen        <= (frame_take || frame_drop) ? 4'h0 : seen_nxt;
      bad         <= frame_drop ? 1'b0 : bad_nxt;
      tcnt        <= (to_expire || conv_last) ? '0 : tcnt + TO_W'(1);
      case (state)
        COLLECT: begin
          if (frame_take) begin
            frame_digit <= digit_nxt;
            acc         <= '0;
            conv_idx    <= 2'd3;
            state       <= CONV;
          end
        end
        CONV: begin
          acc      <= acc_nxt;
          conv_idx <= conv_idx - 2'd1;
          if (conv_last) begin
            score_out   <= acc_nxt;
            score_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [3:0] dp_dig, dp_dig_nxt, dp_frame;

  // Each digit's DP (active-low) travels with its value
  always_comb begin
    dp_dig_nxt = dp_dig;
    if (digit_we) dp_dig_nxt[idx] = seg_q[7];
  end

  // Snapshot DP with the frame and publish it alongside the score
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_dig   <= 4'hF;
      dp_frame <= 4'hF;
      dp_out   <= 4'h0;
    end else begin
      dp_dig <= dp_dig_nxt;
      if (frame_take) dp_frame <= dp_dig_nxt;
      if (conv_last) dp_out <= ~dp_frame;
    end
  end
`else
  assign dp_out = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder: drives scanned digit frames and scores decoded results.
// Expected frames are pushed when their digits are driven and compared against observed score_valid events.
module tb_seven_segment_scan_decoder;
  localparam int SETTLE = 4;
  localparam int TMO    = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anode_signals = 4'hF;
  logic [7:0]  display_out = 8'hFF;
  logic [13:0] score_out;
  logic        score_valid, pattern_err, anode_err, timeout;
  logic [3:0]  dp_out;

  seven_segment_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .SCORE_WIDTH   (14),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .anode_signals(anode_signals),
    .display_out  (display_out),
    .score_out    (score_out),
    .score_valid  (score_valid),
    .pattern_err  (pattern_err),
    .anode_err    (anode_err),
    .timeout      (timeout),
    .dp_out       (dp_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] score;
    logic [3:0]  dp;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int cyc = 0, last_valid_cyc = 0;
  int n_valid = 0, n_perr = 0, n_aerr = 0, n_to = 0;
  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Scan-level reference model of collected digits
  logic [3:0] m_seen = 4'h0;
  logic       m_bad = 1'b0;
  int         m_dig[4];
  logic [3:0] m_dp = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record DUT events away from the active edge
  always @(negedge clk) begin
    if (score_valid === 1'b1) begin
      obs_q.push_back(res_t'({score_out, dp_out}));
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (pattern_err === 1'b1) n_perr++;
    if (anode_err === 1'b1) n_aerr++;
    if (timeout === 1'b1) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: seg_of = 7'b0000001;
      1: seg_of = 7'b1001111;
      2: seg_of = 7'b0010010;
      3: seg_of = 7'b0000110;
      4: seg_of = 7'b1001100;
      5: seg_of = 7'b0100100;
      6: seg_of = 7'b0100000;
      7: seg_of = 7'b0001111;
      8: seg_of = 7'b0000000;
      default: seg_of = 7'b0000100;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_raw(input logic [3:0] an, input logic [7:0] pat, input int hold);
    anode_signals = an;
    display_out   = pat;
    tick(hold);
  endtask

  task automatic scan_digit(input int pos, input int v, input logic dp_lit);
    res_t e;
    scan_raw(~(4'b0001 << pos), {~dp_lit, seg_of(v)}, 8);
    m_dig[pos]  = v;
    m_seen[pos] = 1'b1;
    m_dp[pos]   = dp_lit;
    if (m_seen == 4'hF) begin
      if (!m_bad) begin
        e.score = 14'(m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0]);
`ifdef SEG_SCAN_DP_CAPTURE_EN
        e.dp = m_dp;
`else
        e.dp = 4'b0000;
`endif
        exp_q.push_back(e);
      end
      m_seen = 4'h0;
      m_bad  = 1'b0;
    end
  endtask

  task automatic scan_bad(input int pos, input logic [7:0] pat);
    scan_raw(~(4'b0001 << pos), pat, 8);
    m_seen[pos] = 1'b0;
    m_bad       = 1'b1;
  endtask

  task automatic frame(input int d3, input int d2, input int d1, input int d0, input logic [3:0] dpl);
    scan_digit(3, d3, dpl[3]);
    scan_digit(2, d2, dpl[2]);
    scan_digit(1, d1, dpl[1]);
    scan_digit(0, d0, dpl[0]);
  endtask

  // Blank the display, let outputs appear, then compare observed results against expected
  task automatic drain(input string tag);
    res_t e, o;
    anode_signals = 4'hF;
    display_out   = 8'hFF;
    tick(14);
    check({tag, " count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, " score"}, o.score, e.score);
      check({tag, " dp"}, o.dp, e.dp);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int t0, pe0, ae0, to0, v0;
    logic [3:0] dp_exp;

    // Reset state
    tick(3);
    check("rst score_out", score_out, 0);
    check("rst score_valid", score_valid, 0);
    check("rst pattern_err", pattern_err, 0);
    check("rst anode_err", anode_err, 0);
    check("rst timeout", timeout, 0);
    check("rst dp_out", dp_out, 0);
    reset = 1'b0;
    tick(2);

    // 0042 with leading zeros, plus end-to-end latency from ones digit change
    pe0 = n_perr;
    scan_digit(3, 0, 1'b0);
    scan_digit(2, 0, 1'b0);
    scan_digit(1, 4, 1'b0);
    t0 = cyc;
    scan_digit(0, 2, 1'b0);
    drain("f0042");
    // 2 edges to register and see the change, SETTLE-1 to settle, 1 to sample, 4 of conversion
    check("latency", last_valid_cyc - t0, 2 + (SETTLE - 1) + 1 + 4);
    check("f0042 perr", n_perr - pe0, 0);

    // Maximum value and a mixed one
    frame(9, 9, 9, 9, 4'b0000);
    drain("f9999");
    frame(1, 0, 2, 4, 4'b0000);
    drain("f1024");

    // Short glitch on the completing digit must not be sampled
    pe0 = n_perr;
    scan_digit(3, 5, 1'b0);
    scan_digit(2, 6, 1'b0);
    scan_digit(1, 7, 1'b0);
    scan_raw(4'b1110, {1'b1, seg_of(8)}, SETTLE - 2);
    scan_digit(0, 3, 1'b0);
    drain("glitch");
    check("glitch perr", n_perr - pe0, 0);

    // Non-digit ones pattern spoils its frame until a clean frame completes afterwards
    pe0 = n_perr;
    scan_digit(3, 1, 1'b0);
    scan_digit(2, 2, 1'b0);
    scan_digit(1, 3, 1'b0);
    scan_bad(0, 8'hFF);
    frame(4, 5, 6, 7, 4'b0000);
    frame(8, 0, 0, 1, 4'b0000);
    drain("badpat");
    check("badpat perr", n_perr - pe0, 1);

    // Two anodes low, then an abandoned partial frame
    ae0 = n_aerr;
    pe0 = n_perr;
    to0 = n_to;
    scan_raw(4'b0011, 8'h81, 8);
    scan_raw(4'hF, 8'hFF, 4);
    check("anode_err pulses", n_aerr - ae0, 1);
    scan_digit(3, 1, 1'b0);
    scan_digit(2, 2, 1'b0);
    scan_raw(4'hF, 8'hFF, 2 * TMO + 100);
    m_seen = 4'h0;
    m_bad  = 1'b0;
    check("timeout pulses", n_to - to0, 1);
    check("anode perr", n_perr - pe0, 0);
    drain("partial");

    // Decimal point on tens digit
`ifdef SEG_SCAN_DP_CAPTURE_EN
    dp_exp = 4'b0010;
`else
    dp_exp = 4'b0000;
`endif
    frame(3, 1, 4, 1, 4'b0010);
    drain("dp");
    check("dp_out held", dp_out, dp_exp);

    // Reset while converting aborts the result
    scan_digit(3, 9, 1'b0);
    scan_digit(2, 8, 1'b0);
    scan_digit(1, 7, 1'b0);
    scan_raw(4'b1110, {1'b1, seg_of(6)}, 7);
    v0 = n_valid;
    reset = 1'b1;
    tick(1);
    check("midrst score_out", score_out, 0);
    check("midrst score_valid", score_valid, 0);
    check("midrst dp_out", dp_out, 0);
    check("midrst errs", {pattern_err, anode_err, timeout}, 0);
    tick(1);
    reset = 1'b0;
    m_seen = 4'h0;
    m_bad  = 1'b0;
    scan_raw(4'hF, 8'hFF, 20);
    check("midrst no valid", n_valid - v0, 0);
    frame(0, 0, 0, 7, 4'b0000);
    drain("post rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
